mem_access_stage: RTL

- MEM-stage data-memory controller, directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM register's MEM_* outputs and runs loads and stores on a variable-latency data-memory port.
- Holds the pipeline via MEM_stall while an access is outstanding.
- Registers the retiring instruction's writeback result (ALU result, load data, or link address) into the MEM/WB outputs.

---
 rtl/mem_access_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: issues loads/stores on a variable-latency port,
// stalls the pipeline while outstanding, and registers the MEM/WB writeback result.
// Optional macro MEM_TIMEOUT_EN adds an ACCESS watchdog with a sticky mem_err flag.
module mem_access_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  input  logic [4:0]      MEM_rd,
  input  logic            MEM_we,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  input  logic            MEM_byt,
  input  logic [XLEN-1:0] MEM_link_addr,
  input  logic            MEM_link_we,
  output logic            MEM_stall,
  output logic            dmem_req,
  output logic            dmem_wr,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic [XLEN-1:0] WB_data,
  output logic [4:0]      WB_rd,
  output logic            WB_we,
  output logic            mem_err
);

  if (XLEN != 32 || TIMEOUT == 0) begin : g_bad_cfg
    $error("mem_access_stage: XLEN must be 32 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic            err_q, err_d;

  logic            memop;
  logic            is_store;
  logic [XLEN-1:0] rdata_shifted;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign memop         = MEM_ld | MEM_str;
  assign is_store      = MEM_str & ~MEM_ld;
  assign rdata_shifted = dmem_rdata >> {MEM_alu_out[1:0], 3'b000};

  // Gated by rst_n so a reset mid-access releases the pipeline even while
  // the frozen EX/MEM register still presents a memory op.
  always_comb begin
    MEM_stall = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE:    MEM_stall = memop;
        ACCESS:  MEM_stall = 1'b1;
        default: MEM_stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ld_data_d = ld_data_q;
    err_d     = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (memop) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          wr_d    = is_store;
          addr_d  = {MEM_alu_out[XLEN-1:2], 2'b00};
          wstrb_d = '0;
          wdata_d = '0;
          if (is_store) begin
            if (MEM_byt) begin
              wstrb_d = 4'b0001 << MEM_alu_out[1:0];
              wdata_d = {4{MEM_b2[7:0]}};
            end else begin
              wstrb_d = 4'hF;
              wdata_d = MEM_b2;
            end
          end
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d   = DONE;
          req_d     = 1'b0;
          ld_data_d = MEM_byt ? {{(XLEN-8){1'b0}}, rdata_shifted[7:0]} : dmem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = DONE;
          req_d     = 1'b0;
          err_d     = 1'b1;
          ld_data_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = 1'b0;
    if (!MEM_stall) begin
      wb_rd_d = MEM_rd;
      wb_we_d = MEM_we | MEM_link_we;
      if (MEM_ld)           wb_data_d = ld_data_q;
      else if (MEM_link_we) wb_data_d = MEM_link_addr;
      else                  wb_data_d = MEM_alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ld_data_q <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ld_data_q <= ld_data_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      err_q     <= err_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign dmem_req   = req_q;
  assign dmem_wr    = wr_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign WB_data    = wb_data_q;
  assign WB_rd      = wb_rd_q;
  assign WB_we      = wb_we_q;

endmodule
